serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with a start/done handshake.
- Accepts two operands plus carry-in, and feeds one bit pair per cycle (LSB first) into a single full_adder cell.
- A registered carry is fed back between bits.
- Sits upstream of the full_adder cell. It is the sequencing stage that drives it, giving an area-cheap alternative to a ripple chain in multi-cycle datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..64).

Ports:
- clk      input   1      rising-edge clock
- reset_n  input   1      asynchronous active-low reset
- start    input   1      request an add; sampled only in IDLE
- a        input   WIDTH  operand A; sampled on the accepting edge
- b        input   WIDTH  operand B; sampled on the accepting edge
- cin      input   1      carry-in; sampled on the accepting edge
- busy     output  1      high in RUN and DONE
- done     output  1      one-cycle pulse; sum/cout valid
- sum      output  WIDTH  result; holds until the next accepted start
- cout     output  1      carry-out; holds until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n), with synchronous deassertion handled externally.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers/carry/counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - The cell operates on a_sh[0], b_sh[0], carry.
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]} (shift right, new bit at MSB).
  - a_sh and b_sh shift right by 1 with zero fill.
  - carry <= fa_cout; cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; sum=sum_sh, cout=carry.
  - Next edge: go to IDLE.
- Latency: start accepted at edge E0. done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles from acceptance to done.
- Throughput: one add per WIDTH+2 cycles. start must be re-presented in IDLE.
- start while busy (RUN or DONE): ignored. Inputs a, b, cin may change freely after acceptance with no effect.
- sum/cout update only on the DONE transition and remain stable through IDLE.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, exact WIDTH+1 bits. No truncation beyond the WIDTH+1 result.
- cnt width: max(1, $clog2(WIDTH)). WIDTH=1 gives a single RUN cycle.
- Reset asserted mid-operation: the operation is abandoned immediately. Outputs return to reset values and no done pulse is produced.
- done and busy are registered decodes of state, with no combinational path from inputs.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): the signed two's-complement overflow flag.
  - ovf = carry into the MSB XOR cout, captured during the final RUN cycle.
  - Valid with done and held like sum; reset value 0.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package adder_pkg:
  - state enum type (IDLE, RUN, DONE)
  - localparam function for the counter width
- Sub-module: one instance of the existing full_adder cell for the per-bit sum/carry. No other hierarchy.

Test Plan:
- Reset mid-RUN (WIDTH=8, a=8'hFF, b=8'h01, reset_n low at cycle 3): busy=0, done=0, sum=0, cout=0 immediately. No done after reset release.
- Basic add (WIDTH=8, a=8'h3C, b=8'h15, cin=0): done exactly 9 cycles after accept; sum=8'h51, cout=0; busy high throughout.
- Full carry ripple (a=8'hFF, b=8'h00, cin=1): sum=8'h00, cout=1. With SERIAL_ADDER_OVF_EN: ovf=0.
- Signed overflow (a=8'h7F, b=8'h01, cin=0): sum=8'h80, cout=0, ovf=1. Then (a=8'h80, b=8'h80): sum=8'h00, cout=1, ovf=1.
- start held high continuously, operands changing every cycle:
  - Only first-edge operands are used.
  - The next accept occurs in the IDLE cycle after done; done is spaced every WIDTH+2 cycles.
  - sum is stable between done pulses.
- WIDTH=1 build (a=1, b=1, cin=1): done 2 cycles after accept; sum=1, cout=1.
- Randomised sweep (WIDTH=8 and WIDTH=13, 1000 operand sets checked against a+b+cin): {cout,sum} matches in every case.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared state type and counter-width helper for the serial adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit sum/carry cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with start/done handshake; SERIAL_ADDER_OVF_EN adds signed overflow flag ovf
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_cout, last;
  full_adder u_fa (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .cin(carry),
    .sum(fa_sum),
    .cout(fa_cout)
  );
  // next partial sum: new bit enters at the MSB, earlier bits move toward the LSB
  always_comb begin
    sum_nx = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    last   = cnt == CW'(WIDTH - 1);
  end
  // sequencer: load on accept, one bit per RUN cycle, publish result on entering DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nx;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            sum   <= sum_nx;
            cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ fa_cout;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
